// File: rtl/snn_stage_sequencer.sv
// Frame-level sequencer: enables each selected stage in ascending order, with pause, watchdog and error latch.
// Optional stray-done protocol check under `SNN_SEQ_PROTOCOL_CHECK_EN.
module snn_stage_sequencer #(
    parameter int NUM_STAGES     = 3,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int FRAME_CNT_W    = 16,
    parameter int STAGE_IDX_W    = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [NUM_STAGES-1:0]  stage_mask,
    input  logic                   pause,
    input  logic                   clear_error,
    input  logic [NUM_STAGES-1:0]  stage_done,
    output logic [NUM_STAGES-1:0]  stage_enable,
    output logic                   ready,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   error,
    output logic [STAGE_IDX_W-1:0] err_stage,
    output logic [STAGE_IDX_W-1:0] cur_stage,
    output logic [FRAME_CNT_W-1:0] frame_count
);
    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_STAGES-1:0]  enable_q, enable_d;
    logic [NUM_STAGES-1:0]  mask_q, mask_d;
    logic [STAGE_IDX_W-1:0] cur_q, cur_d;
    logic [STAGE_IDX_W-1:0] err_q, err_d;
    logic [TMR_W-1:0]       timer_q, timer_d;
    logic                   pending_q, pending_d;
    logic                   frame_done_q, frame_done_d;
    logic [FRAME_CNT_W-1:0] count_q, count_d;

    logic                   first_found, next_found, done_cur;
    logic [STAGE_IDX_W-1:0] first_idx, next_idx;
`ifdef SNN_SEQ_PROTOCOL_CHECK_EN
    logic [NUM_STAGES-1:0]  stray;
    logic [STAGE_IDX_W-1:0] stray_idx;
`endif

    // Descending scans so the last hit is the lowest qualifying index.
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        next_found  = 1'b0;
        next_idx    = '0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (stage_mask[i]) begin
                first_found = 1'b1;
                first_idx   = STAGE_IDX_W'(i);
            end
            if (mask_q[i] && (i > int'(cur_q))) begin
                next_found = 1'b1;
                next_idx   = STAGE_IDX_W'(i);
            end
        end
    end

    // In RUN the enable register is exactly the one-hot of cur_stage.
    assign done_cur = |(stage_done & enable_q);

`ifdef SNN_SEQ_PROTOCOL_CHECK_EN
    assign stray = stage_done & ~enable_q;

    always_comb begin
        stray_idx = '0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (stray[i]) begin
                stray_idx = STAGE_IDX_W'(i);
            end
        end
    end
`endif

    always_comb begin
        state_d      = state_q;
        enable_d     = enable_q;
        mask_d       = mask_q;
        cur_d        = cur_q;
        err_d        = err_q;
        timer_d      = timer_q;
        pending_d    = pending_q;
        frame_done_d = 1'b0;
        count_d      = count_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (first_found) begin
                        state_d   = ST_RUN;
                        mask_d    = stage_mask;
                        cur_d     = first_idx;
                        enable_d  = NUM_STAGES'(1) << first_idx;
                        timer_d   = '0;
                        pending_d = 1'b0;
                    end else begin
                        frame_done_d = 1'b1;
                        count_d      = count_q + FRAME_CNT_W'(1);
                    end
                end
            end

            ST_RUN: begin
`ifdef SNN_SEQ_PROTOCOL_CHECK_EN
                if (|stray) begin
                    state_d   = ST_ERROR;
                    enable_d  = '0;
                    err_d     = stray_idx;
                    pending_d = 1'b0;
                end else
`endif
                if (!pause && (done_cur || pending_q)) begin
                    timer_d   = '0;
                    pending_d = 1'b0;
                    if (next_found) begin
                        cur_d    = next_idx;
                        enable_d = NUM_STAGES'(1) << next_idx;
                    end else begin
                        state_d      = ST_IDLE;
                        enable_d     = '0;
                        frame_done_d = 1'b1;
                        count_d      = count_q + FRAME_CNT_W'(1);
                    end
                end else if (pause) begin
                    pending_d = pending_q | done_cur;
                end else if (TIMEOUT_CYCLES > 0) begin
                    // Timer counts completed unpaused cycles; the last allowed one trips the watchdog.
                    if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                        state_d  = ST_ERROR;
                        enable_d = '0;
                        err_d    = cur_q;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
            end

            ST_ERROR: begin
                if (clear_error) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                enable_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            enable_q     <= '0;
            mask_q       <= '0;
            cur_q        <= '0;
            err_q        <= '0;
            timer_q      <= '0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            enable_q     <= enable_d;
            mask_q       <= mask_d;
            cur_q        <= cur_d;
            err_q        <= err_d;
            timer_q      <= timer_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
            count_q      <= count_d;
        end
    end

    assign stage_enable = enable_q;
    assign ready        = (state_q == ST_IDLE);
    assign busy         = (state_q == ST_RUN);
    assign error        = (state_q == ST_ERROR);
    assign frame_done   = frame_done_q;
    assign err_stage    = err_q;
    assign cur_stage    = cur_q;
    assign frame_count  = count_q;
endmodule

// File: tb/tb_snn_stage_sequencer.sv
// Bench for snn_stage_sequencer: queue-based frame model checked every cycle, plus directed literal checks.
module tb_snn_stage_sequencer;
    localparam int NS  = 3;
    localparam int TO  = 8;
    localparam int CW  = 3;
    localparam int IW  = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [NS-1:0] stage_mask = '0;
    logic          pause = 1'b0;
    logic          clear_error = 1'b0;
    logic [NS-1:0] stage_done = '0;
    logic [NS-1:0] stage_enable;
    logic          ready, busy, frame_done, error;
    logic [IW-1:0] err_stage, cur_stage;
    logic [CW-1:0] frame_count;

    int n_checks = 0;
    int n_pass   = 0;

    snn_stage_sequencer #(
        .NUM_STAGES(NS), .TIMEOUT_CYCLES(TO), .FRAME_CNT_W(CW), .STAGE_IDX_W(IW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stage_mask(stage_mask),
        .pause(pause), .clear_error(clear_error), .stage_done(stage_done),
        .stage_enable(stage_enable), .ready(ready), .busy(busy),
        .frame_done(frame_done), .error(error), .err_stage(err_stage),
        .cur_stage(cur_stage), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    // Model: a frame is the list of stages still to run; age is unpaused cycles spent in the head stage.
    int q[$];
    int age = 0;
    bit pend = 0;
    bit m_err = 0;
    bit m_fd = 0;
    int m_cnt = 0;
    int m_errst = 0;
    int m_cur = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete(); age = 0; pend = 0; m_err = 0; m_fd = 0;
            m_cnt = 0; m_errst = 0; m_cur = 0;
        end else begin
            m_fd = 0;
            if (m_err) begin
                if (clear_error) m_err = 0;
            end else if (q.size() == 0) begin
                if (start) begin
                    for (int i = 0; i < NS; i++) if (stage_mask[i]) q.push_back(i);
                    if (q.size() == 0) begin
                        m_fd = 1; m_cnt = (m_cnt + 1) % (1 << CW);
                    end else begin
                        age = 0; pend = 0;
                    end
                end
            end else begin
                int cur;
                bit hit;
                int low;
                bit any_stray;
                cur = q[0];
                hit = stage_done[cur];
                any_stray = 0; low = 0;
                for (int i = NS - 1; i >= 0; i--)
                    if (stage_done[i] && i != cur) begin any_stray = 1; low = i; end
`ifdef SNN_SEQ_PROTOCOL_CHECK_EN
                if (any_stray) begin
                    m_err = 1; m_errst = low; q.delete();
                end else
`endif
                if (!pause && (hit || pend)) begin
                    void'(q.pop_front()); age = 0; pend = 0;
                    if (q.size() == 0) begin
                        m_fd = 1; m_cnt = (m_cnt + 1) % (1 << CW);
                    end
                end else if (pause) begin
                    pend = pend | hit;
                end else begin
                    age++;
                    if (age >= TO) begin m_err = 1; m_errst = cur; q.delete(); end
                end
            end
            if (q.size() != 0) m_cur = q[0];
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            logic [31:0] act, exp;
            logic [NS-1:0] m_en;
            m_en = (q.size() != 0) ? NS'(1 << q[0]) : '0;
            act = {stage_enable, ready, busy, frame_done, error, err_stage, cur_stage, frame_count};
            exp = {m_en, (!m_err && q.size() == 0), (q.size() != 0), m_fd, m_err,
                   IW'(m_errst), IW'(m_cur), CW'(m_cnt)};
            n_checks++;
            if (act === exp) n_pass++;
            else $display("FAIL cycle_model t=%0t actual=%h required=%h", $time, act, exp);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout bench did not finish");
        $fatal(1);
    end

`ifdef SNN_SEQ_PROTOCOL_CHECK_EN
    localparam int CNT_AFTER_T5 = 4;
`else
    localparam int CNT_AFTER_T5 = 5;
`endif

    initial begin
        repeat (2) tick();
        chk("rst_ready", ready, 1);
        chk("rst_enable", stage_enable, 0);
        chk("rst_count", frame_count, 0);
        reset = 1'b0;
        tick();

        // Two-stage frame, 101
        start = 1; stage_mask = 3'b101; tick(); start = 0; stage_mask = 0;
        chk("t1_en_first", stage_enable, 3'b001);
        chk("t1_busy", busy, 1);
        repeat (4) tick();
        stage_done = 3'b001; tick(); stage_done = 0;
        chk("t1_en_second", stage_enable, 3'b100);
        chk("t1_cur", cur_stage, 2);
        repeat (6) tick();
        stage_done = 3'b100; tick(); stage_done = 0;
        chk("t1_fd", frame_done, 1);
        chk("t1_cnt", frame_count, 1);
        chk("t1_ready", ready, 1);
        tick();
        chk("t1_fd_pulse", frame_done, 0);

        // Empty mask, then start while busy
        start = 1; stage_mask = 3'b000; tick(); start = 0;
        chk("t2_fd", frame_done, 1);
        chk("t2_cnt", frame_count, 2);
        chk("t2_en", stage_enable, 0);
        start = 1; stage_mask = 3'b010; tick(); start = 0;
        start = 1; stage_mask = 3'b001; tick(); start = 0; stage_mask = 0;
        chk("t2_ignored", stage_enable, 3'b010);
        stage_done = 3'b010; tick(); stage_done = 0;
        chk("t2_cnt2", frame_count, 3);

        // Pause holds enable, latched done advances after release
        start = 1; stage_mask = 3'b010; tick(); start = 0; stage_mask = 0;
        pause = 1; repeat (3) tick();
        stage_done = 3'b010; tick(); stage_done = 0;
        repeat (5) tick();
        chk("t3_held", stage_enable, 3'b010);
        chk("t3_no_fd", frame_done, 0);
        pause = 0; tick();
        chk("t3_fd", frame_done, 1);
        chk("t3_cnt", frame_count, 4);

        // Watchdog on stage 0, start ignored in ERROR, clear
        start = 1; stage_mask = 3'b001; tick(); start = 0; stage_mask = 0;
        repeat (7) tick();
        chk("t4_pre_err", error, 0);
        tick();
        chk("t4_err", error, 1);
        chk("t4_errst", err_stage, 0);
        chk("t4_en0", stage_enable, 0);
        start = 1; stage_mask = 3'b001; tick(); start = 0; stage_mask = 0;
        chk("t4_stuck", ready, 0);
        clear_error = 1; tick(); clear_error = 0;
        chk("t4_clr", ready, 1);

        // Done on the timeout cycle wins; then stage 1 times out
        start = 1; stage_mask = 3'b011; tick(); start = 0; stage_mask = 0;
        repeat (7) tick();
        stage_done = 3'b001; tick(); stage_done = 0;
        chk("t4_race_noerr", error, 0);
        chk("t4_race_en", stage_enable, 3'b010);
        repeat (8) tick();
        chk("t4_err1", error, 1);
        chk("t4_errst1", err_stage, 1);
        clear_error = 1; tick(); clear_error = 0;
        chk("t4_hold_errst", err_stage, 1);

        // Stray done on stage 2 while stage 0 runs
        start = 1; stage_mask = 3'b101; tick(); start = 0; stage_mask = 0;
        stage_done = 3'b100; tick(); stage_done = 0;
`ifdef SNN_SEQ_PROTOCOL_CHECK_EN
        chk("t5_err", error, 1);
        chk("t5_errst", err_stage, 2);
        clear_error = 1; tick(); clear_error = 0;
`else
        chk("t5_ignored", stage_enable, 3'b001);
        stage_done = 3'b111; tick(); stage_done = 0;
        chk("t5_multi", stage_enable, 3'b100);
        stage_done = 3'b100; tick(); stage_done = 0;
        chk("t5_fd", frame_done, 1);
`endif
        chk("t5_cnt", frame_count, CNT_AFTER_T5);

        // Counter wrap via empty frames
        for (int k = CNT_AFTER_T5; k < (1 << CW); k++) begin
            start = 1; stage_mask = 3'b000; tick(); start = 0;
        end
        chk("wrap_cnt", frame_count, 0);

        // Asynchronous reset mid-run
        start = 1; stage_mask = 3'b010; tick(); start = 0; stage_mask = 0;
        start = 1; stage_mask = 3'b000; tick(); start = 0;
        chk("t6_busy", busy, 1);
        #3 reset = 1; #1;
        chk("t6_en", stage_enable, 0);
        chk("t6_ready", ready, 1);
        chk("t6_busy0", busy, 0);
        chk("t6_cur", cur_stage, 0);
        chk("t6_errst", err_stage, 0);
        tick(); reset = 0;
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/snn_stage_sequencer.md
Name: snn_stage_sequencer

Overview:
Parametrised frame-level controller for the SNN pipeline; generalises the fixed capture/convolution/pooling control bundle to NUM_STAGES stages with per-frame stage selection.
- On a start request, enables each selected stage in ascending index order and waits for that stage's done pulse before advancing.
- Signals frame completion when the last selected stage finishes.
- Adds pause, per-stage timeout watchdog, error latching and frame counting. Sits between the top-level controller and the stage modules.

Parameters:
- NUM_STAGES, 3, number of controlled stages (index 0 runs first); >= 1.
- TIMEOUT_CYCLES, 65535, max unpaused cycles a stage may stay enabled; 0 disables watchdog.
- FRAME_CNT_W, 16, width of completed-frame counter.
- STAGE_IDX_W, $clog2(NUM_STAGES) (min 1), width of stage index outputs.

Ports:
- clk, input, 1, system clock, rising edge.
- reset, input, 1, asynchronous active-high reset.
- start, input, 1, frame request; accepted only when ready=1.
- stage_mask, input, NUM_STAGES, stages to run this frame; sampled with accepted start.
- pause, input, 1, level; freezes advancing and watchdog.
- clear_error, input, 1, pulse; leaves ERROR.
- stage_done, input, NUM_STAGES, per-stage one-cycle completion pulse.
- stage_enable, output, NUM_STAGES, registered level enable, at most one bit high.
- ready, output, 1, high in IDLE.
- busy, output, 1, high in RUN.
- frame_done, output, 1, one-cycle pulse on frame completion.
- error, output, 1, high in ERROR.
- err_stage, output, STAGE_IDX_W, stage index that caused the error.
- cur_stage, output, STAGE_IDX_W, index of the currently enabled stage.
- frame_count, output, FRAME_CNT_W, completed frames, wraps to 0.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, stage_enable=0, ready=1, busy=0, frame_done=0, error=0, err_stage=0, cur_stage=0, frame_count=0, mask_q=0, timer=0. All outputs are registered.
- IDLE, start=1, stage_mask!=0 (edge t):
  - mask_q<=stage_mask.
  - cur_stage<=lowest set bit.
  - At t+1: stage_enable[cur]=1, busy=1, ready=0, timer=0.
- IDLE, start=1, stage_mask==0: stays IDLE; at t+1, frame_done=1 and frame_count+1.
- start while not ready: ignored, no queuing.
- RUN, stage_done[cur_stage]=1 and pause=0 at edge t:
  - If a higher set bit exists in mask_q: at t+1, enable moves directly to the next set bit (no idle gap), cur_stage updates, timer=0.
  - Else: at t+1, stage_enable=0, state=IDLE, ready=1, busy=0, frame_done=1, frame_count+1 (wraps from all-ones to 0).
- RUN with pause=1:
  - stage_enable is held; the timer is frozen.
  - A stage_done[cur] seen while paused is latched in pending_done.
  - The advance occurs on the first edge with pause=0, with identical timing as above.
- stage_done on bits other than cur_stage: ignored, unless the optional feature is enabled.
- Watchdog (TIMEOUT_CYCLES>0):
  - timer increments each unpaused RUN cycle.
  - When timer reaches TIMEOUT_CYCLES with no done: at next edge, state=ERROR, stage_enable=0, busy=0, error=1, err_stage=cur_stage.
  - A stage_done on the same edge as the timeout wins; no error is raised.
- ERROR:
  - start is ignored and ready=0.
  - clear_error=1 at edge t: at t+1, IDLE, error=0, ready=1. err_stage holds its value until the next error.
- Multiple stage_done bits set simultaneously: only the cur_stage bit is acted on.
- NUM_STAGES=1: a degenerate single-stage frame runs identically.

Optional Feature:
- Macro: SNN_SEQ_PROTOCOL_CHECK_EN.
- Defined: in RUN, any stage_done bit other than cur_stage is a protocol violation. Next edge: state=ERROR, stage_enable=0, error=1, err_stage=index of the lowest offending bit. This check takes priority over a simultaneous valid done.
- Not defined: stray done bits are silently ignored; no extra logic is generated.

Test Plan:
- Mask 3'b101, start, then stage_done[0] 5 cycles later and stage_done[2] 7 cycles after that -> stage_enable 001 then 100 with no gap; frame_done pulse one cycle after done[2]; frame_count=1; ready=1.
- start with mask 0 -> no enable; frame_done pulse at t+1; frame_count increments; start while busy is ignored.
- Mask 3'b010, pause high for 10 cycles, done[1] pulsed during pause -> enable held; advance and frame_done occur one cycle after pause falls.
- TIMEOUT_CYCLES=8, mask 3'b001, no done -> error=1, err_stage=0, enable=0 after 8 cycles. clear_error -> ready=1 next cycle. Done arriving exactly at timeout -> no error.
- reset asserted mid-RUN (asynchronously, between edges) -> all outputs return to reset values immediately; frame_count=0.
- With SNN_SEQ_PROTOCOL_CHECK_EN, cur_stage=0, stray done[2] -> error=1, err_stage=2. Without the macro, the same stimulus is ignored and the frame completes normally.
